// File: rtl/fifo_param_pkg.sv
// Shared FIFO write-side types: data width, arbiter state encoding and the
// per-write tag used to route delayed FIFO errors back to their producer.
package fifo_param_pkg;

  localparam int DATA_WIDTH = 16;
  // Wide enough for the largest supported requester count (8).
  localparam int ID_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } err_tag_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the write arbiter, bundled so the
// arbiter and its environment connect through one port.
interface fifo_wr_arbiter_if
  import fifo_param_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_WIDTH
);

  // Handshake: req[i] is a level "valid" with req_wdata[i] stable while high;
  // ack[i] is the "ready" and a word moves exactly on an edge where both are high.
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             ack;
  logic [NUM_REQ-1:0]             req_err;
  logic                           fifo_wr_en;
  logic [DATA_W-1:0]              fifo_wdata;
  logic                           fifo_full;
  logic                           fifo_wr_err;
  arb_state_e                     dbg_state;

  modport master (
    input  req, req_wdata, fifo_full, fifo_wr_err,
    output ack, req_err, fifo_wr_en, fifo_wdata, dbg_state
  );

  modport slave (
    output req, req_wdata, fifo_full, fifo_wr_err,
    input  ack, req_err, fifo_wr_en, fifo_wdata, dbg_state
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request strictly after
// `last`, wrapping around; shared by the read- and write-side arbiters.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] sel
);

  logic [IW-1:0] cand;

  always_comb begin
    any  = 1'b0;
    sel  = '0;
    cand = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last) + i) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        sel = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with bounded bursts and per-write tags for delayed error attribution.
module fifo_wr_arbiter
  import fifo_param_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DATA_WIDTH,
  parameter int MAX_BURST = 4,
  parameter int ERR_LAT   = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  fifo_wr_arbiter_if.master bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      last_q, last_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic               wr_en_q, wr_en_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [NUM_REQ-1:0] req_err_q, req_err_d;
  logic [NUM_REQ-1:0] ack_c;
  err_tag_t           tag_q [ERR_LAT];
  logic               pick_any;
  logic [IW-1:0]      pick_sel;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req  (bus.req),
    .last (last_q),
    .any  (pick_any),
    .sel  (pick_sel)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    wr_en_d = 1'b0;
    wdata_d = wdata_q;
    ack_c   = '0;
    case (state_q)
      IDLE: begin
        if (pick_any && !bus.fifo_full) begin
          ack_c[pick_sel] = 1'b1;
          owner_d = pick_sel;
          burst_d = BW'(1);
          wr_en_d = 1'b1;
          wdata_d = bus.req_wdata[pick_sel];
          state_d = OWN;
        end
      end
      OWN: begin
        // A full FIFO stalls the owner in place; burst_cnt only counts real writes.
        if (bus.req[owner_q] && (burst_q < BW'(MAX_BURST))) begin
          if (!bus.fifo_full) begin
            ack_c[owner_q] = 1'b1;
            burst_d = burst_q + BW'(1);
            wr_en_d = 1'b1;
            wdata_d = bus.req_wdata[owner_q];
          end
        end else begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_err_d = '0;
    if (bus.fifo_wr_err && tag_q[ERR_LAT-1].valid) begin
      req_err_d = NUM_REQ'(1) << tag_q[ERR_LAT-1].id;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= IW'(NUM_REQ - 1);
      burst_q   <= '0;
      wr_en_q   <= 1'b0;
      wdata_q   <= '0;
      req_err_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      wr_en_q   <= wr_en_d;
      wdata_q   <= wdata_d;
      req_err_q <= req_err_d;
    end
  end

  // Stage 0 tags the write currently on fifo_wr_en; owner_q still names its producer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ERR_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: wr_en_q, id: ID_W'(owner_q)};
      for (int i = 1; i < ERR_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // No word may be consumed while reset holds the port.
  assign bus.ack        = nRST ? ack_c : '0;
  assign bus.req_err    = req_err_q;
  assign bus.fifo_wr_en = wr_en_q;
  assign bus.fifo_wdata = wdata_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter: per-cycle ack/enable expectations plus a
// data scoreboard filled on each expected ack and drained by fifo_wr_en.
module tb_fifo_wr_arbiter;
  import fifo_param_pkg::*;

  localparam int NR = 4;
  localparam int DW = DATA_WIDTH;
  localparam int MB = 4;
  localparam int EL = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  int            total = 0;
  int            passed = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  logic [NR-1:0] prev_ack;
  logic [NR-1:0] ea;
  logic [NR-1:0] er;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB), .ERR_LAT(EL)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    bus.req = '0;
    bus.req_wdata = '0;
    bus.fifo_full = 1'b0;
    bus.fifo_wr_err = 1'b0;
    exp_q.delete();
    prev_ack = '0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  task automatic drive_data();
    for (int i = 0; i < NR; i++) bus.req_wdata[i] = DW'($urandom);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (nRST === 1'b1 && bus.fifo_wr_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL wr_unexpected: fifo_wdata=%h written with no expected word", bus.fifo_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.fifo_wdata !== mon_exp)
          $display("FAIL wr_data: fifo_wdata=%h expected %h", bus.fifo_wdata, mon_exp);
        else passed++;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    nRST = 1'b1;
    bus.req = 4'b1111;
    drive_data();
    bus.fifo_full = 1'b0;
    bus.fifo_wr_err = 1'b0;
    prev_ack = '0;
    #2 nRST = 1'b0;
    @(negedge CLK); #1;
    total++; if (bus.fifo_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b expected 0", bus.fifo_wr_en); else passed++;
    total++; if (bus.fifo_wdata !== '0) $display("FAIL rst_wdata: got %h expected 0", bus.fifo_wdata); else passed++;
    total++; if (bus.req_err !== '0) $display("FAIL rst_req_err: got %b expected 0", bus.req_err); else passed++;
    total++; if (bus.ack !== '0) $display("FAIL rst_ack: got %b expected 0", bus.ack); else passed++;
    total++; if (bus.dbg_state !== IDLE) $display("FAIL rst_state: got %0d expected IDLE", bus.dbg_state); else passed++;
    bus.req = '0;
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_burst_limit();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      bus.req = 4'b0001;
      drive_data();
      @(negedge CLK); #1;
      ea = (c % 5 == 4) ? 4'b0000 : 4'b0001;
      total++; if (bus.ack !== ea) $display("FAIL burst_ack c%0d: got %b expected %b", c, bus.ack, ea); else passed++;
      total++; if (bus.fifo_wr_en !== (|prev_ack)) $display("FAIL burst_wr_en c%0d: got %b expected %b", c, bus.fifo_wr_en, |prev_ack); else passed++;
      for (int i = 0; i < NR; i++) if (ea[i]) exp_q.push_back(bus.req_wdata[i]);
      prev_ack = ea;
      tick();
    end
    bus.req = '0;
    repeat (3) tick();
    total++; if (exp_q.size() != 0) $display("FAIL burst_drain: %0d words never written, expected 0", exp_q.size()); else passed++;
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      bus.req = 4'b1111;
      drive_data();
      @(negedge CLK); #1;
      ea = (c % 5 == 4) ? 4'b0000 : (4'b0001 << ((c / 5) % NR));
      total++; if (bus.ack !== ea) $display("FAIL rr_ack c%0d: got %b expected %b", c, bus.ack, ea); else passed++;
      total++; if (bus.fifo_wr_en !== (|prev_ack)) $display("FAIL rr_wr_en c%0d: got %b expected %b", c, bus.fifo_wr_en, |prev_ack); else passed++;
      for (int i = 0; i < NR; i++) if (ea[i]) exp_q.push_back(bus.req_wdata[i]);
      prev_ack = ea;
      tick();
    end
    bus.req = '0;
    repeat (3) tick();
    total++; if (exp_q.size() != 0) $display("FAIL rr_drain: %0d words never written, expected 0", exp_q.size()); else passed++;
  endtask

  task automatic test_full_stall();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      bus.req = 4'b0110;
      bus.fifo_full = (c inside {2, 3, 4, 8});
      drive_data();
      @(negedge CLK); #1;
      if (c inside {0, 1, 5, 6}) ea = 4'b0010;
      else if (c == 9)           ea = 4'b0100;
      else                       ea = 4'b0000;
      total++; if (bus.ack !== ea) $display("FAIL stall_ack c%0d: got %b expected %b", c, bus.ack, ea); else passed++;
      total++; if (bus.fifo_wr_en !== (|prev_ack)) $display("FAIL stall_wr_en c%0d: got %b expected %b", c, bus.fifo_wr_en, |prev_ack); else passed++;
      if (c == 3) begin
        total++; if (bus.dbg_state !== OWN) $display("FAIL stall_state: got %0d expected OWN", bus.dbg_state); else passed++;
      end
      for (int i = 0; i < NR; i++) if (ea[i]) exp_q.push_back(bus.req_wdata[i]);
      prev_ack = ea;
      tick();
    end
    bus.req = '0;
    bus.fifo_full = 1'b0;
    repeat (3) tick();
    total++; if (exp_q.size() != 0) $display("FAIL stall_drain: %0d words never written, expected 0", exp_q.size()); else passed++;
  endtask

  task automatic test_req_drop();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      bus.req = (c < 2) ? 4'b0011 : 4'b0010;
      drive_data();
      @(negedge CLK); #1;
      if (c < 2)       ea = 4'b0001;
      else if (c == 3) ea = 4'b0010;
      else             ea = 4'b0000;
      total++; if (bus.ack !== ea) $display("FAIL drop_ack c%0d: got %b expected %b", c, bus.ack, ea); else passed++;
      total++; if (bus.fifo_wr_en !== (|prev_ack)) $display("FAIL drop_wr_en c%0d: got %b expected %b", c, bus.fifo_wr_en, |prev_ack); else passed++;
      for (int i = 0; i < NR; i++) if (ea[i]) exp_q.push_back(bus.req_wdata[i]);
      prev_ack = ea;
      tick();
    end
    bus.req = '0;
    repeat (3) tick();
    total++; if (exp_q.size() != 0) $display("FAIL drop_drain: %0d words never written, expected 0", exp_q.size()); else passed++;
  endtask

  task automatic test_err_attr();
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      bus.req = (c == 0) ? 4'b0100 : 4'b0000;
      // c3 is ERR_LAT after the write on fifo_wr_en (c1); c2 is early, c7 is stray.
      bus.fifo_wr_err = (c inside {2, 3, 7});
      drive_data();
      @(negedge CLK); #1;
      ea = (c == 0) ? 4'b0100 : 4'b0000;
      er = (c == 4) ? 4'b0100 : 4'b0000;
      total++; if (bus.ack !== ea) $display("FAIL err_ack c%0d: got %b expected %b", c, bus.ack, ea); else passed++;
      total++; if (bus.req_err !== er) $display("FAIL err_req_err c%0d: got %b expected %b", c, bus.req_err, er); else passed++;
      for (int i = 0; i < NR; i++) if (ea[i]) exp_q.push_back(bus.req_wdata[i]);
      prev_ack = ea;
      tick();
    end
    bus.fifo_wr_err = 1'b0;
    total++; if (exp_q.size() != 0) $display("FAIL err_drain: %0d words never written, expected 0", exp_q.size()); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      bus.req = 4'b0010;
      drive_data();
      @(negedge CLK); #1;
      total++; if (bus.ack !== 4'b0010) $display("FAIL mrst_ack c%0d: got %b expected 0010", c, bus.ack); else passed++;
      exp_q.push_back(bus.req_wdata[1]);
      if (c == 0) tick();
    end
    // Second write was acked but reset lands before its edge: it never reaches the FIFO.
    #1 nRST = 1'b0;
    #1;
    void'(exp_q.pop_back());
    total++; if (bus.ack !== '0) $display("FAIL mrst_ack_rst: got %b expected 0", bus.ack); else passed++;
    total++; if (bus.fifo_wr_en !== 1'b0) $display("FAIL mrst_wr_en: got %b expected 0", bus.fifo_wr_en); else passed++;
    total++; if (bus.fifo_wdata !== '0) $display("FAIL mrst_wdata: got %h expected 0", bus.fifo_wdata); else passed++;
    total++; if (bus.req_err !== '0) $display("FAIL mrst_req_err: got %b expected 0", bus.req_err); else passed++;
    total++; if (bus.dbg_state !== IDLE) $display("FAIL mrst_state: got %0d expected IDLE", bus.dbg_state); else passed++;
    bus.req = 4'b0011;
    tick();
    tick();
    total++; if (bus.fifo_wr_en !== 1'b0) $display("FAIL mrst_hold_wr_en: got %b expected 0", bus.fifo_wr_en); else passed++;
    nRST = 1'b1;
    drive_data();
    @(negedge CLK); #1;
    total++; if (bus.ack !== 4'b0001) $display("FAIL mrst_first_grant: got %b expected 0001", bus.ack); else passed++;
    exp_q.push_back(bus.req_wdata[0]);
    tick();
    bus.req = '0;
    repeat (3) tick();
    total++; if (exp_q.size() != 0) $display("FAIL mrst_drain: %0d words never written, expected 0", exp_q.size()); else passed++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_burst_limit();
    test_round_robin();
    test_full_stall();
    test_req_drop();
    test_err_attr();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at 100000 time units, expected completion");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter placed in front of `fifo_write`. It lets NUM_REQ independent producers share the single FIFO write port, with a bounded burst per grant. Each accepted word is tagged with its requester so that a delayed `fifo_wr_err` is returned to the producer that caused it. All outputs toward the FIFO are registered.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, `fifo_param_pkg::DATA_WIDTH`: word width.
- MAX_BURST, 4: maximum consecutive writes per grant, at least 1.
- ERR_LAT, 2: cycles from `fifo_wr_en` high to the matching `fifo_wr_err`.

Ports (clock and reset first):
- CLK  in  1  single clock; all state updates on posedge.
- nRST  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester write request; level-sensitive.
- req_wdata  in  NUM_REQ×DATA_W  per-requester write data.
- ack  out  NUM_REQ  combinational one-hot; high means this requester's word is consumed at the next edge.
- req_err  out  NUM_REQ  registered one-cycle pulse; this requester's write was rejected by the FIFO.
- fifo_wr_en  out  1  registered write enable to `fifo_write`.
- fifo_wdata  out  DATA_W  registered write data.
- fifo_full  in  1  full flag from `fifo_write`.
- fifo_wr_err  in  1  write-error flag from `fifo_write`.

## Operation
- State machine has two states, IDLE and OWN. Registers: `owner` (index), `last` (round-robin pointer), `burst_cnt` (width $clog2(MAX_BURST+1)).
- IDLE
  - If any `req` is high and `fifo_full` is low: select the first requester searching from `last+1`, wrapping modulo NUM_REQ.
  - Assert `ack[sel]`. Load `owner=sel` and `burst_cnt=1`. Register `fifo_wr_en=1` and `fifo_wdata=req_wdata[sel]`. Go to OWN.
  - Otherwise register `fifo_wr_en=0`.
- OWN
  - If `req[owner]` is high, `fifo_full` is low and `burst_cnt<MAX_BURST`: ack and write again, then increment `burst_cnt`.
  - If `req[owner]` is high and `fifo_full` is high: stall with no ack and `fifo_wr_en=0`. Stay in OWN; `burst_cnt` holds.
  - If `req[owner]` is low or `burst_cnt==MAX_BURST`: set `last=owner`, register `fifo_wr_en=0`, go to IDLE. This gives a one-cycle handoff bubble.
- `ack` is at most one-hot. It is always low when `fifo_full` is high or when the arbiter is leaving OWN.
- A request that drops mid-burst is legal. Data is never written without an ack.
- Error attribution:
  - A shift register of depth ERR_LAT carries {valid, id} for each `fifo_wr_en` cycle.
  - When `fifo_wr_err` is high and the entry at depth ERR_LAT is valid, pulse `req_err[id]` on the next cycle.
  - `fifo_wr_err` with no valid entry is ignored.
- Because `fifo_full` lags the memory, overflow is possible. The resulting errors are reported through `req_err`, not prevented.

## Timing
- Reset values:
  - `fifo_wr_en=0`, `fifo_wdata=0`, `req_err=0`.
  - State IDLE, `owner=0`, `burst_cnt=0`.
  - `last=NUM_REQ-1`, so requester 0 has priority first.
  - The tag pipeline is cleared.
- Latency: `req` sampled at edge k produces `ack` combinationally in cycle k. `fifo_wr_en` and `fifo_wdata` are valid after edge k+1.
- Back-to-back writes within a burst run at 1 word per cycle.
- Full bandwidth with two or more active requesters is MAX_BURST words per MAX_BURST+1 cycles.
- `req_err` pulses ERR_LAT+1 cycles after the corresponding `fifo_wr_en`.
- Asynchronous reset mid-burst forces the reset values immediately. In-flight tags are dropped and no `req_err` is raised for them.
- `fifo_full` rising exactly while a burst is being granted blocks that ack in the same cycle.

## Structure
- Shared package `fifo_param_pkg`: `DATA_WIDTH`, an arbiter-state enum (IDLE, OWN), and an `err_tag_t` struct {valid, id}.
- Sub-module `rr_pick`: combinational round-robin priority selector.
  - Inputs: `req` vector, `last` pointer.
  - Outputs: `any`, `sel` index.
  - Reusable by the read-side arbiter.

## Test plan
- **Single requester burst limit:** `req[0]` held, FIFO never full, MAX_BURST=4. Expect writes of req0 data in 4 consecutive cycles, 1 bubble, then 4 more.
- **Round-robin fairness:** `req[3:0]=1111` held. Expect grant order 0,1,2,3,0 in bursts of 4, and `fifo_wdata` matches each owner's data.
- **Full stall:** `fifo_full=1` for 3 cycles mid-burst (after 2 writes). Expect no ack and `fifo_wr_en=0` for 3 cycles, then 2 more writes from the same owner.
- **Error attribution:** force `fifo_wr_err=1` exactly ERR_LAT cycles after a write by requester 2. Expect `req_err=0100` for one cycle; a stray `fifo_wr_err` with no tag gives `req_err=0`.
- **Reset mid-burst:** drop `nRST` during req1's second write. Expect all outputs at reset values immediately; after release with `req=0011`, requester 0 is granted first.
